regfile_access_sequencer: RTL and testbench
===========================================

// Module: regfile_access_sequencer
// PURPOSE
//  Sequences and shares the 16x16 dual-read register file between two requesters: the ALU
//  pipeline (read rs1/rs2, wait for result, write rd) and the RAM load/store unit (write rd
//  from RAM / read rd for store). Owns every register-file control input (opcode, addresses,
//  write data, write enable). Round-robin arbitration, one operation in flight.
// PARAMETERS
//  DATA_WIDTH     16   register/data width
//  ADDR_WIDTH     4    register address width
//  TIMEOUT_CYCLES 255  max ALU_WAIT cycles before abort (counter is 8 bits; legal range 1..255)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset            in   1   asynchronous, active-low reset (0 = reset)
//  alu_req_valid    in   1   ALU request pending
//  alu_req_ready    out  1   request accepted this cycle (valid&&ready)
//  alu_req_func     in   12  ALU function, becomes rf_opcode[11:0]
//  alu_req_rs1/rs2  in   4   source registers
//  alu_req_rd       in   4   destination register
//  alu_operands_vld out  1   regfile read_data_1/2 hold rs1/rs2 this cycle
//  alu_result_valid in   1   ALU result present (sampled only in ALU_WAIT)
//  alu_result       in   16  ALU result
//  mem_req_valid    in   1   memory request pending
//  mem_req_ready    out  1   request accepted this cycle
//  mem_req_is_load  in   1   1 = load (RAM->reg), 0 = store (reg->RAM)
//  mem_req_reg      in   4   register for load/store
//  mem_load_data    in   16  load data, sampled at accept
//  mem_store_valid  out  1   regfile read_data_reg holds store data this cycle
//  alu_timeout      out  1   sticky: an ALU op was aborted
//  err_clear        in   1   clears alu_timeout
//  busy             out  1   state != IDLE
//  rf_opcode        out  16  to register file opcode
//  rf_addr_1/2/3    out  4   to register file addresses
//  rf_write_data    out  16  to register file write data
//  rf_write_enable  out  1   to register file write enable
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, last_grant=MEM (ALU wins
//    first tie), timeout counter 0, alu_timeout 0. Reset mid-op abandons it: no write issued.
//  - Opcodes: ALU {4'b0001,func}; load 16'h9200; store 16'h9100; idle 16'h0000.
//  - IDLE: rf_opcode 0, we 0. Grant one valid requester (ready high one cycle); both valid ->
//    requester not granted last. Capture all request fields at accept. Ready only in IDLE,
//    so >=1 IDLE cycle between ops.
//  - ALU_RD (1 cyc): opcode ALU, addr1=rs1, addr2=rs2, addr3=rd, alu_operands_vld=1 -> ALU_WAIT.
//  - ALU_WAIT: opcode ALU held, we 0, counter++. alu_result_valid -> latch result -> ALU_WB
//    (valid wins over timeout in same cycle). Counter reaching TIMEOUT_CYCLES -> alu_timeout=1,
//    IDLE, no write.
//  - ALU_WB (1 cyc): opcode ALU, addr3=rd, write_data=result, we=1 -> IDLE. Earliest write
//    is 3 cycles after accept.
//  - MEM_LD (1 cyc): opcode 9200, addr3=reg, write_data=load data, we=1 -> IDLE.
//  - MEM_ST (1 cyc): opcode 9100, addr3=reg, mem_store_valid=1, we 0 -> IDLE.
//  - err_clear clears alu_timeout next edge; a timeout in the same cycle wins (stays 1).
//  - Unused addr fields driven 0; write_data 0 whenever we=0.
// TESTING
//  1. ALU rs1=1,rs2=2,rd=3,func=0x001; result 0xBEEF 2 cyc after operands_vld -> single-cycle
//     we, opcode 0x1001, addr3=3, data 0xBEEF; regfile[3]=0xBEEF.
//  2. Both valid after reset, held -> grants ALU, MEM, ALU, MEM; never two grants without IDLE.
//  3. Load reg 5, data 0x1234 -> opcode 0x9200, addr3=5, we one cycle; regfile[5]=0x1234.
//  4. Store reg 3 after test 1 -> opcode 0x9100, mem_store_valid pulse, read_data_reg=0xBEEF, no we.
//  5. No ALU result, TIMEOUT_CYCLES=4 -> alu_timeout=1 after 4 wait cycles, no write, busy=0;
//     err_clear -> 0.
//  6. reset=0 during ALU_WAIT -> all outputs 0 immediately, no write; next tie grants ALU.

Source files
------------

// File: rtl/regfile_access_sequencer_if.sv
// Bundle of every handshake and register-file signal around the sequencer.
//   master : the sequencer side (takes requests/results, drives readies,
//            status flags and all register-file controls)
//   slave  : the requester / register-file side (the mirror image)
// Signals:
//   alu_req_*        ALU pipeline request (valid/ready, func, rs1, rs2, rd)
//   alu_operands_vld register file read ports hold rs1/rs2 this cycle
//   alu_result*      ALU result handshake
//   mem_req_*        load/store request (valid/ready, is_load, reg, load data)
//   mem_store_valid  register file read_data_reg holds store data this cycle
//   alu_timeout      sticky abort flag, cleared by err_clear
//   busy             an operation is in flight
//   rf_*             register file opcode, addresses, write data, write enable
interface regfile_access_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  alu_req_valid;
  logic                  alu_req_ready;
  logic [11:0]           alu_req_func;
  logic [ADDR_WIDTH-1:0] alu_req_rs1;
  logic [ADDR_WIDTH-1:0] alu_req_rs2;
  logic [ADDR_WIDTH-1:0] alu_req_rd;
  logic                  alu_operands_vld;
  logic                  alu_result_valid;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_is_load;
  logic [ADDR_WIDTH-1:0] mem_req_reg;
  logic [DATA_WIDTH-1:0] mem_load_data;
  logic                  mem_store_valid;
  logic                  alu_timeout;
  logic                  err_clear;
  logic                  busy;
  logic [15:0]           rf_opcode;
  logic [ADDR_WIDTH-1:0] rf_addr_1;
  logic [ADDR_WIDTH-1:0] rf_addr_2;
  logic [ADDR_WIDTH-1:0] rf_addr_3;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic                  rf_write_enable;

  modport master (
    input  alu_req_valid, alu_req_func, alu_req_rs1, alu_req_rs2, alu_req_rd,
           alu_result_valid, alu_result, mem_req_valid, mem_req_is_load,
           mem_req_reg, mem_load_data, err_clear,
    output alu_req_ready, alu_operands_vld, mem_req_ready, mem_store_valid,
           alu_timeout, busy, rf_opcode, rf_addr_1, rf_addr_2, rf_addr_3,
           rf_write_data, rf_write_enable
  );

  modport slave (
    output alu_req_valid, alu_req_func, alu_req_rs1, alu_req_rs2, alu_req_rd,
           alu_result_valid, alu_result, mem_req_valid, mem_req_is_load,
           mem_req_reg, mem_load_data, err_clear,
    input  alu_req_ready, alu_operands_vld, mem_req_ready, mem_store_valid,
           alu_timeout, busy, rf_opcode, rf_addr_1, rf_addr_2, rf_addr_3,
           rf_write_data, rf_write_enable
  );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Shares a 16x16 dual-read register file between the ALU pipeline and the
// RAM load/store unit. Round-robin arbitration, one operation in flight,
// every register-file control and every output comes straight from a flop.
// Ports:
//   clk   clock, all state on the rising edge
//   reset asynchronous, active-low (0 = reset)
//   bus   regfile_access_sequencer_if.master (requests, status, rf controls)
module regfile_access_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  regfile_access_sequencer_if.master bus
);

  localparam logic [15:0] OPC_LOAD     = 16'h9200;
  localparam logic [15:0] OPC_STORE    = 16'h9100;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ALU_RD, ALU_WAIT, ALU_WB, MEM_LD, MEM_ST} state_t;

  state_t                state_reg, state_next;
  logic                  alu_ready_reg, alu_ready_next;
  logic                  mem_ready_reg, mem_ready_next;
  logic                  last_mem_reg, last_mem_next;   // 1: last grant went to MEM
  logic [7:0]            count_reg, count_next;
  logic                  timeout_reg, timeout_next;
  logic                  busy_reg, busy_next;
  logic                  operands_vld_reg, operands_vld_next;
  logic                  store_valid_reg, store_valid_next;
  logic [15:0]           opcode_reg, opcode_next;
  logic [ADDR_WIDTH-1:0] addr1_reg, addr1_next;
  logic [ADDR_WIDTH-1:0] addr2_reg, addr2_next;
  logic [ADDR_WIDTH-1:0] addr3_reg, addr3_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  we_reg, we_next;
  logic [11:0]           func_reg, func_next;
  logic [ADDR_WIDTH-1:0] rd_reg, rd_next;
  logic                  timeout_event;

  always_comb begin
    state_next        = state_reg;
    alu_ready_next    = 1'b0;
    mem_ready_next    = 1'b0;
    last_mem_next     = last_mem_reg;
    count_next        = count_reg;
    func_next         = func_reg;
    rd_next           = rd_reg;
    timeout_event     = 1'b0;
    operands_vld_next = 1'b0;
    store_valid_next  = 1'b0;
    opcode_next       = 16'h0000;
    addr1_next        = '0;
    addr2_next        = '0;
    addr3_next        = '0;
    wdata_next        = '0;
    we_next           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (alu_ready_reg && bus.alu_req_valid) begin
          state_next        = ALU_RD;
          last_mem_next     = 1'b0;
          func_next         = bus.alu_req_func;
          rd_next           = bus.alu_req_rd;
          opcode_next       = {4'b0001, bus.alu_req_func};
          addr1_next        = bus.alu_req_rs1;
          addr2_next        = bus.alu_req_rs2;
          addr3_next        = bus.alu_req_rd;
          operands_vld_next = 1'b1;
        end else if (mem_ready_reg && bus.mem_req_valid) begin
          last_mem_next = 1'b1;
          addr3_next    = bus.mem_req_reg;
          if (bus.mem_req_is_load) begin
            state_next  = MEM_LD;
            opcode_next = OPC_LOAD;
            wdata_next  = bus.mem_load_data;
            we_next     = 1'b1;
          end else begin
            state_next       = MEM_ST;
            opcode_next      = OPC_STORE;
            store_valid_next = 1'b1;
          end
        end else if (!alu_ready_reg && !mem_ready_reg) begin
          // Ready is a registered offer; a withdrawn offer re-arbitrates
          // one cycle later instead of being re-issued immediately.
          if (bus.alu_req_valid && (!bus.mem_req_valid || last_mem_reg)) begin
            alu_ready_next = 1'b1;
          end else if (bus.mem_req_valid) begin
            mem_ready_next = 1'b1;
          end
        end
      end
      ALU_RD: begin
        state_next  = ALU_WAIT;
        count_next  = 8'd0;
        opcode_next = {4'b0001, func_reg};
      end
      ALU_WAIT: begin
        // A result arriving in the final wait cycle still beats the abort.
        if (bus.alu_result_valid) begin
          state_next  = ALU_WB;
          opcode_next = {4'b0001, func_reg};
          addr3_next  = rd_reg;
          wdata_next  = bus.alu_result;
          we_next     = 1'b1;
        end else if (count_reg == TIMEOUT_LAST) begin
          state_next    = IDLE;
          timeout_event = 1'b1;
        end else begin
          count_next  = count_reg + 8'd1;
          opcode_next = {4'b0001, func_reg};
        end
      end
      ALU_WB, MEM_LD, MEM_ST: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
    // A new abort takes priority over a simultaneous clear.
    if (timeout_event) begin
      timeout_next = 1'b1;
    end else if (bus.err_clear) begin
      timeout_next = 1'b0;
    end else begin
      timeout_next = timeout_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      alu_ready_reg    <= 1'b0;
      mem_ready_reg    <= 1'b0;
      last_mem_reg     <= 1'b1;
      count_reg        <= 8'd0;
      timeout_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      operands_vld_reg <= 1'b0;
      store_valid_reg  <= 1'b0;
      opcode_reg       <= 16'h0000;
      addr1_reg        <= '0;
      addr2_reg        <= '0;
      addr3_reg        <= '0;
      wdata_reg        <= '0;
      we_reg           <= 1'b0;
      func_reg         <= 12'h000;
      rd_reg           <= '0;
    end else begin
      state_reg        <= state_next;
      alu_ready_reg    <= alu_ready_next;
      mem_ready_reg    <= mem_ready_next;
      last_mem_reg     <= last_mem_next;
      count_reg        <= count_next;
      timeout_reg      <= timeout_next;
      busy_reg         <= busy_next;
      operands_vld_reg <= operands_vld_next;
      store_valid_reg  <= store_valid_next;
      opcode_reg       <= opcode_next;
      addr1_reg        <= addr1_next;
      addr2_reg        <= addr2_next;
      addr3_reg        <= addr3_next;
      wdata_reg        <= wdata_next;
      we_reg           <= we_next;
      func_reg         <= func_next;
      rd_reg           <= rd_next;
    end
  end

  assign bus.alu_req_ready    = alu_ready_reg;
  assign bus.mem_req_ready    = mem_ready_reg;
  assign bus.alu_operands_vld = operands_vld_reg;
  assign bus.mem_store_valid  = store_valid_reg;
  assign bus.alu_timeout      = timeout_reg;
  assign bus.busy             = busy_reg;
  assign bus.rf_opcode        = opcode_reg;
  assign bus.rf_addr_1        = addr1_reg;
  assign bus.rf_addr_2        = addr2_reg;
  assign bus.rf_addr_3        = addr3_reg;
  assign bus.rf_write_data    = wdata_reg;
  assign bus.rf_write_enable  = we_reg;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: directed scenarios plus a randomized
// sequence checked against an expected register-file image and write log.
module tb_regfile_access_sequencer;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rf_init = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc_n = 0;

  typedef struct {
    logic [15:0] op;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         wr_q[$];
  int          grant_q[$];   // 0 = ALU, 1 = MEM
  int          gcyc_q[$];
  logic [15:0] rf[16];
  logic [15:0] exp_rf[16];
  logic [15:0] read_data_1, read_data_2, read_data_reg;

  regfile_access_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus();

  regfile_access_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Register file model driven by the sequencer's controls.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0100 + 16'(i);
    end else if (bus.rf_write_enable) begin
      rf[bus.rf_addr_3] <= bus.rf_write_data;
    end
  end
  assign read_data_1   = rf[bus.rf_addr_1];
  assign read_data_2   = rf[bus.rf_addr_2];
  assign read_data_reg = rf[bus.rf_addr_3];

  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    if (reset && bus.rf_write_enable) wr_q.push_back('{bus.rf_opcode, bus.rf_addr_3, bus.rf_write_data});
    if (bus.alu_req_valid && bus.alu_req_ready) begin grant_q.push_back(0); gcyc_q.push_back(cyc_n); end
    if (bus.mem_req_valid && bus.mem_req_ready) begin grant_q.push_back(1); gcyc_q.push_back(cyc_n); end
  end

  // Offer an ALU request and return in the cycle after it is accepted.
  task automatic start_alu(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                           input logic [11:0] func, output bit ok);
    ok = 1'b0;
    bus.alu_req_rs1 = rs1; bus.alu_req_rs2 = rs2; bus.alu_req_rd = rd; bus.alu_req_func = func;
    bus.alu_req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.alu_req_ready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    bus.alu_req_valid = 1'b0;
  endtask

  task automatic start_mem(input bit is_load, input logic [3:0] r, input logic [15:0] d, output bit ok);
    ok = 1'b0;
    bus.mem_req_is_load = is_load; bus.mem_req_reg = r; bus.mem_load_data = d;
    bus.mem_req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req_ready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.alu_req_valid = 1'b1; bus.mem_req_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.rf_opcode !== 16'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 0000", bus.rf_opcode); end
    checks++; if ({bus.rf_write_enable, bus.rf_write_data} !== 17'h0) begin errors++; $display("FAIL reset_write: got we=%b data=%h expected 0/0000", bus.rf_write_enable, bus.rf_write_data); end
    checks++; if ({bus.rf_addr_1, bus.rf_addr_2, bus.rf_addr_3} !== 12'h0) begin errors++; $display("FAIL reset_addr: got %h%h%h expected 000", bus.rf_addr_1, bus.rf_addr_2, bus.rf_addr_3); end
    checks++; if ({bus.alu_req_ready, bus.mem_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", bus.alu_req_ready, bus.mem_req_ready); end
    checks++; if ({bus.busy, bus.alu_timeout, bus.alu_operands_vld, bus.mem_store_valid} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b%b expected 0000", bus.busy, bus.alu_timeout, bus.alu_operands_vld, bus.mem_store_valid); end
    bus.alu_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
    rf_init = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  // Both requesters held valid straight after reset: grants must alternate, ALU first.
  task automatic test_tie_round_robin();
    int n0;
    n0 = grant_q.size();
    bus.alu_req_rs1 = 4'd4; bus.alu_req_rs2 = 4'd5; bus.alu_req_rd = 4'd7; bus.alu_req_func = 12'h0AB;
    bus.alu_result = 16'h7777; bus.alu_result_valid = 1'b1;
    bus.mem_req_is_load = 1'b1; bus.mem_req_reg = 4'd8; bus.mem_load_data = 16'h8888;
    bus.alu_req_valid = 1'b1; bus.mem_req_valid = 1'b1;
    for (int k = 0; k < 100 && grant_q.size() < n0 + 4; k++) @(negedge clk);
    bus.alu_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
    checks++; if (grant_q.size() !== n0 + 4) begin errors++; $display("FAIL rr_grant_count: got %0d expected %0d", grant_q.size() - n0, 4); end
    for (int i = 0; i < 4 && n0 + i < grant_q.size(); i++) begin
      checks++; if (grant_q[n0+i] !== i % 2) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_q[n0+i], i % 2); end
      if (i > 0) begin
        checks++; if (gcyc_q[n0+i] - gcyc_q[n0+i-1] < 2) begin errors++; $display("FAIL rr_gap[%0d]: got %0d cycles expected >=2", i, gcyc_q[n0+i] - gcyc_q[n0+i-1]); end
      end
      $display("grant %0d -> %s", i, grant_q[n0+i] == 0 ? "ALU" : "MEM");
    end
    repeat (3) @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_rf[7] = 16'h7777; exp_rf[8] = 16'h8888;
    checks++; if (rf[7] !== exp_rf[7]) begin errors++; $display("FAIL rr_rf7: got %h expected %h", rf[7], exp_rf[7]); end
    checks++; if (rf[8] !== exp_rf[8]) begin errors++; $display("FAIL rr_rf8: got %h expected %h", rf[8], exp_rf[8]); end
  endtask

  task automatic test_alu_basic();
    bit ok; int w0;
    w0 = wr_q.size();
    start_alu(4'd1, 4'd2, 4'd3, 12'h001, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alu_accept: got no ready expected ready within 20 cycles"); end
    checks++; if ({bus.alu_operands_vld, bus.rf_opcode} !== {1'b1, 16'h1001}) begin errors++; $display("FAIL alu_rd_cycle: got vld=%b op=%h expected 1/1001", bus.alu_operands_vld, bus.rf_opcode); end
    checks++; if ({bus.rf_addr_1, bus.rf_addr_2, bus.rf_addr_3} !== 12'h123) begin errors++; $display("FAIL alu_rd_addr: got %h%h%h expected 123", bus.rf_addr_1, bus.rf_addr_2, bus.rf_addr_3); end
    checks++; if ({read_data_1, read_data_2} !== {exp_rf[1], exp_rf[2]}) begin errors++; $display("FAIL alu_operands: got %h/%h expected %h/%h", read_data_1, read_data_2, exp_rf[1], exp_rf[2]); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.rf_write_enable, bus.alu_operands_vld, bus.rf_opcode} !== {3'b100, 16'h1001}) begin errors++; $display("FAIL alu_wait: got busy=%b we=%b vld=%b op=%h expected 1/0/0/1001", bus.busy, bus.rf_write_enable, bus.alu_operands_vld, bus.rf_opcode); end
    @(negedge clk);
    bus.alu_result = 16'hBEEF; bus.alu_result_valid = 1'b1;
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    checks++; if ({bus.rf_write_enable, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_data} !== {1'b1, 16'h1001, 4'd3, 16'hBEEF}) begin errors++; $display("FAIL alu_wb: got we=%b op=%h a3=%h d=%h expected 1/1001/3/beef", bus.rf_write_enable, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_data); end
    @(negedge clk);
    exp_rf[3] = 16'hBEEF;
    checks++; if ({bus.rf_write_enable, bus.rf_write_data, bus.busy} !== 18'h0) begin errors++; $display("FAIL alu_after_wb: got we=%b d=%h busy=%b expected 0/0000/0", bus.rf_write_enable, bus.rf_write_data, bus.busy); end
    checks++; if (wr_q.size() !== w0 + 1) begin errors++; $display("FAIL alu_write_count: got %0d expected 1", wr_q.size() - w0); end
    checks++; if (rf[3] !== exp_rf[3]) begin errors++; $display("FAIL alu_rf3: got %h expected %h", rf[3], exp_rf[3]); end
    $display("alu rd=3 result=beef");
  endtask

  task automatic test_load();
    bit ok;
    start_mem(1'b1, 4'd5, 16'h1234, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ld_accept: got no ready expected ready within 20 cycles"); end
    checks++; if ({bus.rf_write_enable, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_data, bus.mem_store_valid} !== {1'b1, 16'h9200, 4'd5, 16'h1234, 1'b0}) begin errors++; $display("FAIL ld_cycle: got we=%b op=%h a3=%h d=%h st=%b expected 1/9200/5/1234/0", bus.rf_write_enable, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_data, bus.mem_store_valid); end
    @(negedge clk);
    exp_rf[5] = 16'h1234;
    checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL ld_we_pulse: got %b expected 0", bus.rf_write_enable); end
    checks++; if (rf[5] !== exp_rf[5]) begin errors++; $display("FAIL ld_rf5: got %h expected %h", rf[5], exp_rf[5]); end
    $display("load reg=5 data=1234");
  endtask

  task automatic test_store();
    bit ok; int w0;
    w0 = wr_q.size();
    start_mem(1'b0, 4'd3, 16'h0000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL st_accept: got no ready expected ready within 20 cycles"); end
    checks++; if ({bus.mem_store_valid, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_enable} !== {1'b1, 16'h9100, 4'd3, 1'b0}) begin errors++; $display("FAIL st_cycle: got st=%b op=%h a3=%h we=%b expected 1/9100/3/0", bus.mem_store_valid, bus.rf_opcode, bus.rf_addr_3, bus.rf_write_enable); end
    checks++; if (read_data_reg !== exp_rf[3]) begin errors++; $display("FAIL st_data: got %h expected %h", read_data_reg, exp_rf[3]); end
    @(negedge clk);
    checks++; if ({bus.mem_store_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL st_pulse: got st=%b busy=%b expected 0/0", bus.mem_store_valid, bus.busy); end
    checks++; if (wr_q.size() !== w0) begin errors++; $display("FAIL st_no_write: got %0d writes expected 0", wr_q.size() - w0); end
    $display("store reg=3 data=%h", read_data_reg);
  endtask

  task automatic test_timeout();
    bit ok; int w0;
    // No result at all: abort after TO wait cycles.
    w0 = wr_q.size();
    start_alu(4'd0, 4'd1, 4'd9, 12'h055, ok);
    repeat (TO) @(negedge clk);
    checks++; if ({bus.busy, bus.alu_timeout} !== 2'b10) begin errors++; $display("FAIL to_not_early: got busy=%b to=%b expected 1/0", bus.busy, bus.alu_timeout); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.alu_timeout, bus.rf_opcode} !== {2'b01, 16'h0}) begin errors++; $display("FAIL to_abort: got busy=%b to=%b op=%h expected 0/1/0000", bus.busy, bus.alu_timeout, bus.rf_opcode); end
    checks++; if (wr_q.size() !== w0) begin errors++; $display("FAIL to_no_write: got %0d writes expected 0", wr_q.size() - w0); end
    @(negedge clk);
    checks++; if (bus.alu_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus.alu_timeout); end
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    checks++; if (bus.alu_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", bus.alu_timeout); end
    $display("alu rd=9 timed out");
    // Result in the last allowed wait cycle wins over the abort.
    w0 = wr_q.size();
    start_alu(4'd0, 4'd1, 4'd12, 12'h066, ok);
    repeat (TO) @(negedge clk);
    bus.alu_result = 16'hC0DE; bus.alu_result_valid = 1'b1;
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    checks++; if ({bus.rf_write_enable, bus.rf_addr_3, bus.rf_write_data} !== {1'b1, 4'd12, 16'hC0DE}) begin errors++; $display("FAIL to_last_cycle_wb: got we=%b a3=%h d=%h expected 1/c/c0de", bus.rf_write_enable, bus.rf_addr_3, bus.rf_write_data); end
    @(negedge clk);
    exp_rf[12] = 16'hC0DE;
    checks++; if ({bus.alu_timeout, wr_q.size() - w0} !== {1'b0, 32'd1}) begin errors++; $display("FAIL to_last_cycle_flag: got to=%b writes=%0d expected 0/1", bus.alu_timeout, wr_q.size() - w0); end
    $display("alu rd=12 result=c0de on last wait cycle");
    // err_clear held through an abort: the abort sets the flag, the clear acts a cycle later.
    bus.err_clear = 1'b1;
    start_alu(4'd0, 4'd1, 4'd13, 12'h077, ok);
    repeat (TO + 1) @(negedge clk);
    checks++; if (bus.alu_timeout !== 1'b1) begin errors++; $display("FAIL to_beats_clear: got %b expected 1", bus.alu_timeout); end
    @(negedge clk);
    bus.err_clear = 1'b0;
    checks++; if (bus.alu_timeout !== 1'b0) begin errors++; $display("FAIL to_clear_after: got %b expected 0", bus.alu_timeout); end
    $display("alu rd=13 timed out with err_clear held");
  endtask

  task automatic test_reset_mid_op();
    bit ok; int w0; int n0;
    w0 = wr_q.size();
    start_alu(4'd1, 4'd2, 4'd10, 12'h0F0, ok);
    @(negedge clk);
    bus.alu_result = 16'hDEAD; bus.alu_result_valid = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.rf_opcode, bus.rf_write_enable, bus.rf_addr_3} !== 22'h0) begin errors++; $display("FAIL mid_reset_outputs: got busy=%b op=%h we=%b a3=%h expected all 0", bus.busy, bus.rf_opcode, bus.rf_write_enable, bus.rf_addr_3); end
    @(negedge clk);
    reset = 1'b1;
    bus.alu_result_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_q.size() !== w0) begin errors++; $display("FAIL mid_reset_no_write: got %0d writes expected 0", wr_q.size() - w0); end
    // Tie after reset goes to the ALU.
    n0 = grant_q.size();
    bus.alu_req_rs1 = 4'd1; bus.alu_req_rs2 = 4'd2; bus.alu_req_rd = 4'd11; bus.alu_req_func = 12'h123;
    bus.alu_result = 16'h6666; bus.alu_result_valid = 1'b1;
    bus.mem_req_is_load = 1'b0; bus.mem_req_reg = 4'd3;
    bus.alu_req_valid = 1'b1; bus.mem_req_valid = 1'b1;
    for (int k = 0; k < 20 && grant_q.size() == n0; k++) @(negedge clk);
    bus.alu_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
    checks++; if (grant_q.size() <= n0 || grant_q[grant_q.size()-1] !== 0) begin errors++; $display("FAIL mid_reset_tie: got grants=%0d expected first grant ALU", grant_q.size() - n0); end
    repeat (3) @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_rf[11] = 16'h6666;
    checks++; if (rf[11] !== exp_rf[11]) begin errors++; $display("FAIL mid_reset_rf11: got %h expected %h", rf[11], exp_rf[11]); end
    $display("reset mid-op, then alu rd=11 result=6666");
  endtask

  task automatic test_random();
    bit ok; int w0; int kind; int lat;
    logic [3:0] rs1, rs2, rd; logic [11:0] func; logic [15:0] val;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      rs1 = 4'($urandom); rs2 = 4'($urandom); rd = 4'($urandom);
      func = 12'($urandom); val = 16'($urandom);
      w0 = wr_q.size();
      if (kind == 0) begin
        lat = int'($urandom_range(1, TO + 2));
        start_alu(rs1, rs2, rd, func, ok);
        checks++; if ({ok, bus.alu_operands_vld, read_data_1, read_data_2} !== {2'b11, exp_rf[rs1], exp_rf[rs2]}) begin errors++; $display("FAIL rnd_operands[%0d]: got ok=%b vld=%b %h/%h expected 1/1/%h/%h", n, ok, bus.alu_operands_vld, read_data_1, read_data_2, exp_rf[rs1], exp_rf[rs2]); end
        if (lat <= TO) begin
          repeat (lat) @(negedge clk);
          bus.alu_result = val; bus.alu_result_valid = 1'b1;
          @(negedge clk);
          bus.alu_result_valid = 1'b0;
          @(negedge clk);
          exp_rf[rd] = val;
          checks++; if (wr_q.size() !== w0 + 1 || wr_q[wr_q.size()-1] != '{{4'b0001, func}, rd, val}) begin errors++; $display("FAIL rnd_alu_write[%0d]: got %0d writes expected one of op=%h a=%h d=%h", n, wr_q.size() - w0, {4'b0001, func}, rd, val); end
          $display("rnd %0d alu rd=%h lat=%0d result=%h", n, rd, lat, val);
        end else begin
          repeat (TO + 1) @(negedge clk);
          checks++; if ({bus.alu_timeout, bus.busy, wr_q.size() - w0} !== {2'b10, 32'd0}) begin errors++; $display("FAIL rnd_timeout[%0d]: got to=%b busy=%b writes=%0d expected 1/0/0", n, bus.alu_timeout, bus.busy, wr_q.size() - w0); end
          bus.err_clear = 1'b1;
          @(negedge clk);
          bus.err_clear = 1'b0;
          $display("rnd %0d alu rd=%h timed out", n, rd);
        end
      end else if (kind == 1) begin
        start_mem(1'b1, rd, val, ok);
        @(negedge clk);
        exp_rf[rd] = val;
        checks++; if (!ok || wr_q.size() !== w0 + 1 || wr_q[wr_q.size()-1] != '{16'h9200, rd, val}) begin errors++; $display("FAIL rnd_load[%0d]: got ok=%b writes=%0d expected one of op=9200 a=%h d=%h", n, ok, wr_q.size() - w0, rd, val); end
        $display("rnd %0d load reg=%h data=%h", n, rd, val);
      end else begin
        start_mem(1'b0, rd, val, ok);
        checks++; if ({ok, bus.mem_store_valid, bus.rf_opcode, read_data_reg} !== {2'b11, 16'h9100, exp_rf[rd]}) begin errors++; $display("FAIL rnd_store[%0d]: got ok=%b st=%b op=%h data=%h expected 1/1/9100/%h", n, ok, bus.mem_store_valid, bus.rf_opcode, read_data_reg, exp_rf[rd]); end
        @(negedge clk);
        checks++; if (wr_q.size() !== w0) begin errors++; $display("FAIL rnd_store_no_write[%0d]: got %0d writes expected 0", n, wr_q.size() - w0); end
        $display("rnd %0d store reg=%h data=%h", n, rd, exp_rf[rd]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rf[i] !== exp_rf[i]) begin errors++; $display("FAIL rnd_final_rf[%0d]: got %h expected %h", i, rf[i], exp_rf[i]); end
    end
  endtask

  initial begin
    bus.alu_req_valid = 1'b0; bus.alu_req_func = 12'h0; bus.alu_req_rs1 = 4'h0;
    bus.alu_req_rs2 = 4'h0; bus.alu_req_rd = 4'h0; bus.alu_result_valid = 1'b0;
    bus.alu_result = 16'h0; bus.mem_req_valid = 1'b0; bus.mem_req_is_load = 1'b0;
    bus.mem_req_reg = 4'h0; bus.mem_load_data = 16'h0; bus.err_clear = 1'b0;
    for (int i = 0; i < 16; i++) exp_rf[i] = 16'h0100 + 16'(i);
    repeat (3) @(negedge clk);
    test_reset();
    test_tie_round_robin();
    test_alu_basic();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
